// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
// Groups the request, branch-redirect, memory handshake and status signals
// of the instruction fetch stage into one bundle.
// Signal prefixes are given from the fetch unit's point of view:
//   i_start        request fetch of the next instruction
//   i_branchTaken  redirect PC to i_branchTarget (single-cycle pulse)
//   i_branchTarget redirect address, low two bits ignored
//   i_memData      memory read data, valid while i_mfc is high
//   i_mfc          memory function complete
//   o_memRead      memory read strobe
//   o_memAddr      word address of the current read
//   o_ir           latched instruction word
//   o_irValid      o_ir holds a freshly fetched, non-squashed word
//   o_pc           address of the next instruction to fetch
//   o_busy         high while a fetch is waiting on memory
//   o_fetchFault   last fetch timed out, sticky until the next accepted start
// Modports: master drives requests and memory responses, slave is the fetch unit.
interface instr_fetch_unit_if;
  logic        i_start;
  logic        i_branchTaken;
  logic [31:0] i_branchTarget;
  logic [31:0] i_memData;
  logic        i_mfc;
  logic        o_memRead;
  logic [31:0] o_memAddr;
  logic [31:0] o_ir;
  logic        o_irValid;
  logic [31:0] o_pc;
  logic        o_busy;
  logic        o_fetchFault;

  modport master (
    output i_start, i_branchTaken, i_branchTarget, i_memData, i_mfc,
    input  o_memRead, o_memAddr, o_ir, o_irValid, o_pc, o_busy, o_fetchFault
  );

  modport slave (
    input  i_start, i_branchTaken, i_branchTarget, i_memData, i_mfc,
    output o_memRead, o_memAddr, o_ir, o_irValid, o_pc, o_busy, o_fetchFault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Multi-cycle instruction fetch stage. On a start request it reads one word
// through a read/MFC handshake, latches it into the instruction register and
// advances the PC. Branch redirects are accepted at any time; a redirect that
// arrives while a read is outstanding squashes the returning word. A fetch
// that sees no MFC for TIMEOUT cycles is abandoned and flagged as a fault.
// Ports:
//   i_clk  sole clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    instr_fetch_unit_if.slave (request, memory and status signals)
// Parameters:
//   RESET_PC  PC after reset, word aligned
//   TIMEOUT   WAIT cycles without MFC before a fault (1..255)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input logic               i_clk,
  input logic               i_rst,
  instr_fetch_unit_if.slave bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_memAddr;
  logic [31:0] r_ir;
  logic        r_irValid;
  logic        r_memRead;
  logic        r_fetchFault;
  logic        r_pendValid;
  logic [31:0] r_pendTarget;
  logic [7:0]  r_count;

  state_t      w_stateNext;
  logic [31:0] w_pcNext;
  logic [31:0] w_memAddrNext;
  logic [31:0] w_irNext;
  logic        w_irValidNext;
  logic        w_memReadNext;
  logic        w_fetchFaultNext;
  logic        w_pendValidNext;
  logic [31:0] w_pendTargetNext;
  logic [7:0]  w_countNext;

  logic [31:0] w_brTarget;
  logic        w_squash;
  logic [31:0] w_squashTarget;

  // A redirect in the current cycle always beats one stored earlier in the
  // same fetch, so the newest target is the one the PC ends up on.
  assign w_brTarget     = bus.i_branchTarget & 32'hFFFF_FFFC;
  assign w_squash       = bus.i_branchTaken | r_pendValid;
  assign w_squashTarget = bus.i_branchTaken ? w_brTarget : r_pendTarget;

  // State and datapath registers; reset aborts any fetch in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_memAddr    <= RESET_PC;
      r_ir         <= 32'h0;
      r_irValid    <= 1'b0;
      r_memRead    <= 1'b0;
      r_fetchFault <= 1'b0;
      r_pendValid  <= 1'b0;
      r_pendTarget <= 32'h0;
      r_count      <= 8'd0;
    end else begin
      r_state      <= w_stateNext;
      r_pc         <= w_pcNext;
      r_memAddr    <= w_memAddrNext;
      r_ir         <= w_irNext;
      r_irValid    <= w_irValidNext;
      r_memRead    <= w_memReadNext;
      r_fetchFault <= w_fetchFaultNext;
      r_pendValid  <= w_pendValidNext;
      r_pendTarget <= w_pendTargetNext;
      r_count      <= w_countNext;
    end
  end

  // Next-state and next-register logic. Everything holds by default; each
  // state only overrides what it changes.
  always_comb begin
    w_stateNext      = r_state;
    w_pcNext         = r_pc;
    w_memAddrNext    = r_memAddr;
    w_irNext         = r_ir;
    w_irValidNext    = r_irValid;
    w_memReadNext    = r_memRead;
    w_fetchFaultNext = r_fetchFault;
    w_pendValidNext  = r_pendValid;
    w_pendTargetNext = r_pendTarget;
    w_countNext      = r_count;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_memAddrNext    = bus.i_branchTaken ? w_brTarget : r_pc;
          w_pcNext         = bus.i_branchTaken ? w_brTarget : r_pc;
          w_memReadNext    = 1'b1;
          w_irValidNext    = 1'b0;
          w_fetchFaultNext = 1'b0;
          w_countNext      = 8'd0;
          w_pendValidNext  = 1'b0;
          w_stateNext      = S_WAIT;
        end else if (bus.i_branchTaken) begin
          w_pcNext = w_brTarget;
        end
      end

      S_WAIT: begin
        if (bus.i_mfc) begin
          // Completion wins over a timeout landing in the same cycle.
          w_memReadNext   = 1'b0;
          w_pendValidNext = 1'b0;
          w_stateNext     = S_IDLE;
          if (w_squash) begin
            w_pcNext = w_squashTarget;
          end else begin
            w_irNext      = bus.i_memData;
            w_irValidNext = 1'b1;
            w_pcNext      = r_memAddr + 32'd4;
          end
        end else if (r_count == (TIMEOUT - 8'd1)) begin
          w_fetchFaultNext = 1'b1;
          w_memReadNext    = 1'b0;
          w_pendValidNext  = 1'b0;
          w_stateNext      = S_IDLE;
          if (w_squash) begin
            w_pcNext = w_squashTarget;
          end
        end else begin
          w_countNext = r_count + 8'd1;
          if (bus.i_branchTaken) begin
            w_pendValidNext  = 1'b1;
            w_pendTargetNext = w_brTarget;
          end
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign bus.o_memRead    = r_memRead;
  assign bus.o_memAddr    = r_memAddr;
  assign bus.o_ir         = r_ir;
  assign bus.o_irValid    = r_irValid;
  assign bus.o_pc         = r_pc;
  assign bus.o_busy       = (r_state == S_WAIT);
  assign bus.o_fetchFault = r_fetchFault;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch stage that sits directly upstream of the condition-check logic. On request it reads one 32-bit word from memory through a read/MFC (memory function complete) handshake, latches it into the instruction register `IR`, and advances the program counter. The downstream condition check evaluates `IR[31:28]` against the status flags. The block also accepts branch redirects and reports a fetch fault when memory fails to answer within a bounded number of cycles.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `TIMEOUT`, 8'd255: number of WAIT cycles without MFC before a fault is declared (legal range 1..255).

- `Clk`  in  1: sole clock; all state updates on rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `Start`  in  1: request fetch of the next instruction; sampled only in IDLE.
- `BranchTaken`  in  1: redirect PC to `BranchTarget`; single-cycle pulse.
- `BranchTarget`  in  32: redirect address; bits [1:0] are forced to 0 internally.
- `MemData`  in  32: read data from memory; valid when `MFC`=1.
- `MFC`  in  1: memory function complete; sampled only in WAIT.
- `MemRead`  out  1: memory read strobe.
- `MemAddr`  out  32: word address of the current read.
- `IR`  out  32: latched instruction word, fed to the condition check.
- `IRValid`  out  1: `IR` holds a freshly fetched, non-squashed word.
- `PC`  out  32: address of the next instruction to fetch.
- `Busy`  out  1: 1 while in WAIT.
- `FetchFault`  out  1: the last fetch timed out; sticky until the next accepted `Start`.

## Operation
- Two states, IDLE and WAIT. `Busy` is 1 exactly when the block is in WAIT.
- Reset (async, takes effect immediately) sets the following, aborting any fetch in progress:
  - state=IDLE
  - `PC`=`RESET_PC`, `MemAddr`=`RESET_PC`
  - `IR`=0, `IRValid`=0
  - `MemRead`=0, `FetchFault`=0
  - pending-branch flag=0, timeout counter=0
- IDLE behaviour:
  - `BranchTaken`=1 without `Start`: `PC`<=`{BranchTarget[31:2],2'b00}`. Stay in IDLE.
  - `Start`=1: fetch address A is the branch target if `BranchTaken`=1 in the same cycle, otherwise `PC`. Load `MemAddr`<=A, `PC`<=A, `MemRead`<=1, `IRValid`<=0, `FetchFault`<=0, counter<=0. Go to WAIT.
- WAIT behaviour (`MemRead` and `MemAddr` held stable; `Start` ignored):
  - `BranchTaken`=1: set the pending flag and store the aligned target. A later branch in the same WAIT overwrites the stored target.
  - `MFC`=1, no pending branch, and `BranchTaken`=0 this cycle: `IR`<=`MemData`, `IRValid`<=1, `PC`<=`MemAddr`+4, `MemRead`<=0. Go to IDLE.
  - `MFC`=1 with a pending branch or `BranchTaken`=1 this cycle: the word is squashed. `IR` is unchanged, `IRValid` stays 0, `PC`<=the newest target, `MemRead`<=0, pending flag cleared. Go to IDLE.
  - `MFC`=0 with counter=`TIMEOUT`-1: `FetchFault`<=1, `MemRead`<=0, `IR` and `IRValid` unchanged (0). `PC`<=the pending target if one is set, else unchanged. Pending flag cleared. Go to IDLE.
  - `MFC`=0 otherwise: counter<=counter+1.
- Arithmetic: `PC`+4 is modulo 2^32, so 32'hFFFF_FFFC+4 = 0. The counter is 8 bits and never wraps, because the timeout fires first.

## Timing
- `Start` sampled at edge k: `MemRead`=1 and `MemAddr` valid after edge k.
- `MFC` first seen high at edge m (m ≥ k+1): `IR`/`IRValid` update and `MemRead` drops after edge m.
- Minimum latency from `Start` to `IRValid` is 2 edges.
- `IRValid` is a level: it stays 1 until the edge that accepts the next `Start`, or until Reset.
- `MFC`=1 in the timeout cycle: completion wins and no fault is raised.
- Fault is raised after exactly `TIMEOUT` consecutive WAIT cycles with `MFC`=0.
- All outputs are registered; no input-to-output combinational path.

## Test plan
- **Reset then fetch.** `Reset` pulse, then `Start` with `MFC` high on the first WAIT cycle and `MemData`=32'hE3A0_1005 → `MemAddr`=0, `IR`=32'hE3A0_1005, `IRValid`=1 two edges after `Start`, `PC`=4.
- **Delayed MFC.** `MFC` held off 5 cycles → `MemRead` and `MemAddr` stable for 6 cycles, `Busy`=1 throughout; `IR` loads on the `MFC` edge.
- **Branch in IDLE and mid-WAIT.** `BranchTaken` with `BranchTarget`=32'h0000_0103 in IDLE → `PC`=32'h100. A branch to 32'h200 during WAIT, followed by `MFC` → `IRValid`=0, `IR` unchanged, `PC`=32'h200.
- **Timeout.** `TIMEOUT`=4 and `MFC` never asserted → `FetchFault`=1 and `MemRead`=0 after exactly 4 WAIT cycles, `PC` unchanged. The next `Start` clears `FetchFault`. Also run with `MFC` arriving on the 4th cycle → no fault.
- **Wrap and reset mid-fetch.** `PC`=32'hFFFF_FFFC fetch → `PC`=0 afterwards. `Reset` asserted during WAIT → all outputs return to their reset values immediately, without waiting for a clock edge.
